// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared widths, issue-mode encodings and FSM state type for the issue controller
package issue_ctrl_pkg;
  localparam int STALLBUS_WD = 6;
  localparam int INST_WD = 32;
  localparam int ADDR_WD = 32;
  localparam logic SINGLE_ISSUE = 1'b0;
  localparam logic DUAL_ISSUE = 1'b1;
  typedef logic [INST_WD-1:0] inst_t;
  typedef logic [ADDR_WD-1:0] addr_t;
  typedef enum logic {NORMAL, DS_WAIT} state_t;
endpackage

// File: rtl/issue_ctrl_inst_classify.sv
// inst_classify: decodes one instruction word into branch/mem/special flags, destination and source registers
module inst_classify
  import issue_ctrl_pkg::*;
(
  input  inst_t      inst,
  output logic       branch,
  output logic       mem,
  output logic       special,
  output logic [4:0] dest,
  output logic [4:0] rs,
  output logic [4:0] rt
);
  logic [5:0] op;
  logic [5:0] fn;
  logic is_r;
  logic regimm_br;
  logic link;
  logic jr;
  logic unused_shamt;
  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign rs = inst[25:21];
  assign rt = inst[20:16];
  assign unused_shamt = ^inst[10:6];
  assign is_r = op == 6'b000000;
  assign regimm_br = op == 6'b000001 && rt[3:1] == 3'b000;
  assign jr = is_r && fn == 6'b001000;
  assign link = op == 6'b000011 || (regimm_br && rt[4]);
  assign branch = regimm_br || op[5:2] == 4'b0001 || op[5:1] == 5'b00001 || (is_r && fn[5:1] == 5'b00100);
  assign mem = op[5:4] == 2'b10;
  assign special = op == 6'b010000 || (is_r && (fn[5:2] == 4'b0110 || fn[5:2] == 4'b0100 || fn[5:1] == 5'b00110));
  assign dest = link ? 5'd31 : is_r ? (jr ? 5'd0 : inst[15:11]) : (op[5:3] == 3'b101 || branch) ? 5'd0 : rt;
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: decides single/dual issue from the instruction buffer head and registers the decode lanes
module issue_ctrl
  import issue_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [STALLBUS_WD-1:0] stall,
  input  inst_t                  inst1_i,
  input  inst_t                  inst2_i,
  input  addr_t                  inst1_addr_i,
  input  addr_t                  inst2_addr_i,
  input  logic                   inst1_valid_i,
  input  logic                   inst2_valid_i,
  output logic                   issue_o,
  output logic                   issue_mode_o,
  output inst_t                  id_inst1_o,
  output inst_t                  id_inst2_o,
  output addr_t                  id_pc1_o,
  output addr_t                  id_pc2_o,
  output logic                   id_valid1_o,
  output logic                   id_valid2_o,
  output logic                   id_ds1_o
);
  state_t state;
  logic br1, br2, mem1, mem2, sp1, sp2;
  logic [4:0] d1, d2, rs2, rt2, unused_rs1, unused_rt1;
  logic hazard, dual, unused_stall;
  assign unused_stall = ^{stall[STALLBUS_WD-1:4], stall[1:0]};
  inst_classify c1 (
    .inst(inst1_i), .branch(br1), .mem(mem1), .special(sp1), .dest(d1), .rs(unused_rs1), .rt(unused_rt1)
  );
  inst_classify c2 (
    .inst(inst2_i), .branch(br2), .mem(mem2), .special(sp2), .dest(d2), .rs(rs2), .rt(rt2)
  );
  // issue decision: pop strobe and single/dual mode for the current buffer head
  always_comb begin
    hazard = d1 != 5'd0 && (d1 == rs2 || d1 == rt2 || d1 == d2);
    issue_o = rst && inst1_valid_i && !flush && !stall[2];
    dual = issue_o && state == NORMAL && !br1 && inst2_valid_i && !sp1 && !sp2 && !br2 && !(mem1 && mem2) && !hazard;
    issue_mode_o = dual ? DUAL_ISSUE : SINGLE_ISSUE;
  end
  // delay-slot FSM and decode lane registers; flush beats stall, stall[3] holds, stall[2] alone bubbles
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= NORMAL;
      id_inst1_o <= '0;
      id_inst2_o <= '0;
      id_pc1_o <= '0;
      id_pc2_o <= '0;
      id_valid1_o <= 1'b0;
      id_valid2_o <= 1'b0;
      id_ds1_o <= 1'b0;
    end else if (flush) begin
      state <= NORMAL;
      id_valid1_o <= 1'b0;
      id_valid2_o <= 1'b0;
      id_ds1_o <= 1'b0;
    end else begin
      if (issue_o) state <= (state == NORMAL && br1) ? DS_WAIT : NORMAL;
      if (!stall[3]) begin
        id_valid1_o <= issue_o;
        id_valid2_o <= dual;
        id_ds1_o <= issue_o && state == DS_WAIT;
        if (!stall[2]) begin
          id_inst1_o <= inst1_i;
          id_inst2_o <= inst2_i;
          id_pc1_o <= inst1_addr_i;
          id_pc2_o <= inst2_addr_i;
        end
      end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: scoreboard bench for issue_ctrl issue decisions, delay slots, flush, stall and reset
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;
  typedef struct packed {logic v1; logic v2; logic ds; logic [31:0] i1; logic [31:0] i2; logic [31:0] pc1; logic [31:0] pc2;} exp_t;
  typedef struct packed {exp_t e; logic full;} sb_t;
  typedef struct packed {logic [31:0] i1; logic [31:0] p1; logic v1; logic [31:0] i2; logic [31:0] p2; logic v2; logic f; logic [5:0] s; logic iss; logic dual; logic ds;} row_t;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [31:0] A = 32'h00221821;
  localparam logic [31:0] B = 32'h00853021;
  localparam logic [31:0] C = 32'h00622021;
  localparam logic [31:0] D = 32'h00851821;
  localparam logic [31:0] BEQ = 32'h10220003;
  localparam logic [31:0] LW = 32'h8C220000;
  localparam logic [31:0] SW = 32'hAC430004;
  localparam logic [31:0] SW2 = 32'hAC640004;
  localparam logic [31:0] MULT = 32'h00430018;
  localparam logic [31:0] LUI = 32'h3C030001;
  localparam logic [31:0] Z = 32'h00220021;
  localparam logic [31:0] R0 = 32'h00002021;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [5:0] stall = 6'd0;
  logic [31:0] inst1 = 32'd0, inst2 = 32'd0, pc1 = 32'd0, pc2 = 32'd0;
  logic v1 = 1'b0, v2 = 1'b0;
  logic issue_o, issue_mode_o, id_valid1_o, id_valid2_o, id_ds1_o;
  logic [31:0] id_inst1_o, id_inst2_o, id_pc1_o, id_pc2_o;
  exp_t m = '0;
  sb_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .inst1_i(inst1), .inst2_i(inst2), .inst1_addr_i(pc1), .inst2_addr_i(pc2),
    .inst1_valid_i(v1), .inst2_valid_i(v2),
    .issue_o(issue_o), .issue_mode_o(issue_mode_o),
    .id_inst1_o(id_inst1_o), .id_inst2_o(id_inst2_o), .id_pc1_o(id_pc1_o), .id_pc2_o(id_pc2_o),
    .id_valid1_o(id_valid1_o), .id_valid2_o(id_valid2_o), .id_ds1_o(id_ds1_o)
  );
  function automatic exp_t act();
    exp_t a;
    a = '{id_valid1_o, id_valid2_o, id_ds1_o, id_inst1_o, id_inst2_o, id_pc1_o, id_pc2_o};
    return a;
  endfunction
  function automatic row_t mk(input logic [31:0] i1, p1, input logic a1, input logic [31:0] i2, p2, input logic a2,
                              input logic f, input logic [5:0] s, input logic iss, dual, ds);
    row_t r;
    r = '{i1, p1, a1, i2, p2, a2, f, s, iss, dual, ds};
    return r;
  endfunction
  task automatic step(input row_t r);
    @(negedge clk);
    inst1 = r.i1; pc1 = r.p1; v1 = r.v1; inst2 = r.i2; pc2 = r.p2; v2 = r.v2; flush = r.f; stall = r.s;
    if (r.f) begin
      m.v1 = 1'b0; m.v2 = 1'b0; m.ds = 1'b0;
    end else if (!r.s[3]) begin
      m.v1 = r.iss; m.v2 = r.dual; m.ds = r.ds;
      if (!r.s[2]) begin
        m.i1 = r.i1; m.i2 = r.i2; m.pc1 = r.p1; m.pc2 = r.p2;
      end
    end
    q.push_back('{m, m.v1 || (r.s[2] && !r.f)});
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    inst1 = A; pc1 = 32'hBFC00000; v1 = 1'b1; inst2 = B; pc2 = 32'hBFC00004; v2 = 1'b1;
    #1;
    n_checks++;
    if (act() !== '0 || issue_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: lanes %h issue %b, required all 0", act(), issue_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (act() !== '0 || issue_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_held: lanes %h issue %b, required all 0", act(), issue_o);
    end
    @(negedge clk);
    v1 = 1'b0; v2 = 1'b0;
    rst = 1'b1;
    m = '0;
  endtask
  task automatic test_pairs;
    logic [31:0] ta [13] = '{A, A, LW, LW, MULT, B, B, LW, Z, A, LUI, A, SW};
    logic [31:0] tc [13] = '{B, C, SW, SW2, B, MULT, BEQ, B, R0, B, C, D, C};
    logic tv2 [13] = '{T, T, T, T, T, T, T, T, T, F, T, T, T};
    logic td [13] = '{T, F, F, F, F, F, F, T, T, F, F, F, T};
    sb_t s;
    exp_t a;
    for (int i = 0; i < 14; i++) begin
      if (i < 13) step(mk(ta[i], 32'hBFC00000 + 32'(8 * i), T, tc[i], 32'hBFC00004 + 32'(8 * i), tv2[i], F, 6'd0, T, td[i], F));
      else step(mk(A, 32'hBFC00100, F, B, 32'hBFC00104, T, F, 6'd0, F, F, F));
      n_checks++;
      if (issue_o !== (i < 13) || issue_mode_o !== ((i < 13 && td[i % 13]) ? DUAL_ISSUE : SINGLE_ISSUE)) begin
        n_fail++; $display("FAIL pairs[%0d] issue: got %b/%b", i, issue_o, issue_mode_o);
      end
      @(posedge clk); #1;
      s = q.pop_front(); a = act();
      n_checks++;
      if (s.full ? a !== s.e : {a.v1, a.v2, a.ds} !== {s.e.v1, s.e.v2, s.e.ds}) begin
        n_fail++; $display("FAIL pairs[%0d] lanes: got %h required %h", i, a, s.e);
      end
    end
  endtask
  task automatic test_branch;
    row_t rows [7];
    sb_t s;
    exp_t a;
    rows[0] = mk(BEQ, 32'h100, T, B, 32'h104, T, F, 6'd0, T, F, F);
    rows[1] = mk(B, 32'h104, F, A, 32'h108, T, F, 6'd0, F, F, F);
    rows[2] = mk(B, 32'h104, T, A, 32'h108, T, F, 6'd0, T, F, T);
    rows[3] = mk(A, 32'h108, T, B, 32'h10C, T, F, 6'd0, T, T, F);
    rows[4] = mk(BEQ, 32'h110, T, BEQ, 32'h114, T, F, 6'd0, T, F, F);
    rows[5] = mk(BEQ, 32'h114, T, A, 32'h118, T, F, 6'd0, T, F, T);
    rows[6] = mk(A, 32'h118, T, B, 32'h11C, T, F, 6'd0, T, T, F);
    foreach (rows[i]) begin
      step(rows[i]);
      n_checks++;
      if (issue_o !== rows[i].iss || issue_mode_o !== (rows[i].dual ? DUAL_ISSUE : SINGLE_ISSUE)) begin
        n_fail++; $display("FAIL branch[%0d] issue: got %b/%b required %b/%b", i, issue_o, issue_mode_o, rows[i].iss, rows[i].dual);
      end
      @(posedge clk); #1;
      s = q.pop_front(); a = act();
      n_checks++;
      if (s.full ? a !== s.e : {a.v1, a.v2, a.ds} !== {s.e.v1, s.e.v2, s.e.ds}) begin
        n_fail++; $display("FAIL branch[%0d] lanes: got %h required %h", i, a, s.e);
      end
    end
  endtask
  task automatic test_flush;
    row_t rows [5];
    sb_t s;
    exp_t a;
    rows[0] = mk(BEQ, 32'h200, T, B, 32'h204, T, F, 6'd0, T, F, F);
    rows[1] = mk(B, 32'h204, T, A, 32'h208, T, T, 6'd0, F, F, F);
    rows[2] = mk(BEQ, 32'h210, T, B, 32'h214, T, F, 6'd0, T, F, F);
    rows[3] = mk(B, 32'h214, T, A, 32'h218, T, F, 6'd0, T, F, T);
    rows[4] = mk(A, 32'h218, T, B, 32'h21C, T, F, 6'd0, T, T, F);
    foreach (rows[i]) begin
      step(rows[i]);
      n_checks++;
      if (issue_o !== rows[i].iss || issue_mode_o !== (rows[i].dual ? DUAL_ISSUE : SINGLE_ISSUE)) begin
        n_fail++; $display("FAIL flush[%0d] issue: got %b/%b required %b/%b", i, issue_o, issue_mode_o, rows[i].iss, rows[i].dual);
      end
      @(posedge clk); #1;
      s = q.pop_front(); a = act();
      n_checks++;
      if (s.full ? a !== s.e : {a.v1, a.v2, a.ds} !== {s.e.v1, s.e.v2, s.e.ds}) begin
        n_fail++; $display("FAIL flush[%0d] lanes: got %h required %h", i, a, s.e);
      end
    end
    flush = 1'b0;
  endtask
  task automatic test_stall;
    row_t rows [7];
    sb_t s;
    exp_t a;
    rows[0] = mk(A, 32'h300, T, B, 32'h304, T, F, 6'd0, T, T, F);
    rows[1] = mk(C, 32'h308, T, B, 32'h30C, T, F, 6'b001100, F, F, F);
    rows[2] = mk(C, 32'h308, T, B, 32'h30C, T, F, 6'b000100, F, F, F);
    rows[3] = mk(BEQ, 32'h310, T, B, 32'h314, T, F, 6'd0, T, F, F);
    rows[4] = mk(B, 32'h314, T, A, 32'h318, T, F, 6'b001100, F, F, F);
    rows[5] = mk(B, 32'h314, T, A, 32'h318, T, F, 6'b000100, F, F, F);
    rows[6] = mk(B, 32'h314, T, A, 32'h318, T, F, 6'd0, T, F, T);
    foreach (rows[i]) begin
      step(rows[i]);
      n_checks++;
      if (issue_o !== rows[i].iss || issue_mode_o !== (rows[i].dual ? DUAL_ISSUE : SINGLE_ISSUE)) begin
        n_fail++; $display("FAIL stall[%0d] issue: got %b/%b required %b/%b", i, issue_o, issue_mode_o, rows[i].iss, rows[i].dual);
      end
      @(posedge clk); #1;
      s = q.pop_front(); a = act();
      n_checks++;
      if (s.full ? a !== s.e : {a.v1, a.v2, a.ds} !== {s.e.v1, s.e.v2, s.e.ds}) begin
        n_fail++; $display("FAIL stall[%0d] lanes: got %h required %h", i, a, s.e);
      end
    end
    stall = 6'd0;
  endtask
  task automatic test_reset_mid;
    sb_t s;
    exp_t a;
    step(mk(BEQ, 32'h400, T, B, 32'h404, T, F, 6'd0, T, F, F));
    @(posedge clk); #1;
    s = q.pop_front(); a = act();
    n_checks++;
    if (a !== s.e) begin
      n_fail++; $display("FAIL reset_mid pre: got %h required %h", a, s.e);
    end
    @(negedge clk);
    inst1 = A; pc1 = 32'h408; v1 = 1'b1; inst2 = B; pc2 = 32'h40C; v2 = 1'b1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (act() !== '0 || issue_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid async: lanes %h issue %b, required all 0", act(), issue_o);
    end
    rst = 1'b1;
    m = '{T, T, F, A, B, 32'h408, 32'h40C};
    q.push_back('{m, T});
    #1;
    n_checks++;
    if (issue_o !== 1'b1 || issue_mode_o !== DUAL_ISSUE) begin
      n_fail++; $display("FAIL reset_mid first_issue: got %b/%b required 1/dual", issue_o, issue_mode_o);
    end
    @(posedge clk); #1;
    s = q.pop_front(); a = act();
    n_checks++;
    if (a !== s.e) begin
      n_fail++; $display("FAIL reset_mid lanes: got %h required %h", a, s.e);
    end
  endtask
  initial begin
    test_reset;
    test_pairs;
    test_branch;
    test_flush;
    test_stall;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
